// File: rtl/tlk2711_axi_slave_bfm.sv
// AXI4 slave responder for tlk2711_top benches: queued reads returning a 16-bit-lane counting
// pattern, length-checked writes with B responses. Define AXI_BFM_BACKPRESSURE_EN for LFSR stalls.
module tlk2711_axi_slave_bfm #(
  parameter int          DATA_WIDTH = 128,
  parameter int          ADDR_WIDTH = 40,
  parameter int          ID_WIDTH   = 4,
  parameter int          AR_DEPTH   = 4,
  parameter int          RD_LATENCY = 4,
  parameter logic [15:0] PAT_STEP   = 16'h8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  input  logic [ID_WIDTH-1:0]     s_arid,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic [7:0]              s_arlen,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  output logic [ID_WIDTH-1:0]     s_rid,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rlast,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [ID_WIDTH-1:0]     s_awid,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [7:0]              s_awlen,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wlast,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  output logic [ID_WIDTH-1:0]     s_bid,
  output logic [1:0]              s_bresp,
  output logic [31:0]             o_rd_beats,
  output logic [31:0]             o_wr_beats,
  output logic                    o_wr_err
);
  // Every channel transfers on the cycle where valid and ready are both high at clk; a source
  // keeps its payload stable while valid is high and ready is low.
  localparam int LANES = DATA_WIDTH / 16;
  localparam int QA    = $clog2(AR_DEPTH);
  localparam int QENT  = ID_WIDTH + 8;

  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_BURST} rd_state_t;
  typedef enum logic [1:0] {W_ADDR, W_DATA, W_RESP} wr_state_t;

  rd_state_t rd_state, rd_next;
  wr_state_t wr_state, wr_next;

  logic                  active;
  logic [QENT-1:0]       q_mem [AR_DEPTH];
  logic [QA-1:0]         q_wp, q_rp;
  logic [QA:0]           q_cnt;
  logic                  q_push, q_pop, bp_ok;
  logic [7:0]            lat_cnt, beat_cnt, w_len, wcnt;
  logic [ID_WIDTH-1:0]   r_id, w_id;
  logic [DATA_WIDTH-1:0] pattern;
  logic                  w_err, r_hs, w_hs, w_last_exp;
  logic                  unused_inputs;

  assign unused_inputs = ^{s_araddr, s_awaddr, s_wdata, s_wstrb};

  // Holds every ready low while rst is asserted, since the queue and write FSM reset to "ready" states.
  always_ff @(posedge clk) begin
    if (!rst) active <= 1'b0;
    else      active <= 1'b1;
  end

`ifdef AXI_BFM_BACKPRESSURE_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk) begin
    if (!rst) lfsr <= 16'hACE1;
    else      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign bp_ok = (lfsr[1:0] != 2'b00);
`else
  assign bp_ok = 1'b1;
`endif

  assign s_arready = active && (q_cnt != (QA+1)'(AR_DEPTH));
  assign q_push    = s_arvalid && s_arready;
  assign q_pop     = (rd_state == RD_IDLE) && (q_cnt != '0);

  always_ff @(posedge clk) begin
    if (q_push) q_mem[q_wp] <= {s_arid, s_arlen};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_wp  <= '0;
      q_rp  <= '0;
      q_cnt <= '0;
    end else begin
      if (q_push) q_wp <= q_wp + 1'b1;
      if (q_pop)  q_rp <= q_rp + 1'b1;
      case ({q_push, q_pop})
        2'b10:   q_cnt <= q_cnt + 1'b1;
        2'b01:   q_cnt <= q_cnt - 1'b1;
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  assign s_rvalid = (rd_state == RD_BURST) && bp_ok;
  assign s_rlast  = (rd_state == RD_BURST) && (beat_cnt == 8'd0);
  assign s_rid    = r_id;
  assign s_rdata  = pattern;
  assign s_rresp  = 2'b00;
  assign r_hs     = s_rvalid && s_rready;

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE:  if (q_cnt != '0) rd_next = RD_WAIT;
      RD_WAIT:  if (lat_cnt == 8'd0) rd_next = RD_BURST;
      RD_BURST: if (r_hs && s_rlast) rd_next = RD_IDLE;
      default:  rd_next = RD_IDLE;
    endcase
  end

  // Pattern is never reloaded between bursts, so consecutive bursts continue the count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_state   <= RD_IDLE;
      lat_cnt    <= '0;
      beat_cnt   <= '0;
      r_id       <= '0;
      o_rd_beats <= '0;
      for (int i = 0; i < LANES; i++) pattern[i*16 +: 16] <= 16'(i);
    end else begin
      rd_state <= rd_next;
      if (q_pop) begin
        lat_cnt  <= 8'(RD_LATENCY);
        beat_cnt <= q_mem[q_rp][7:0];
        r_id     <= q_mem[q_rp][QENT-1:8];
      end else if (rd_state == RD_WAIT && lat_cnt != 8'd0) begin
        lat_cnt <= lat_cnt - 8'd1;
      end
      if (r_hs) begin
        beat_cnt   <= beat_cnt - 8'd1;
        o_rd_beats <= o_rd_beats + 32'd1;
        for (int i = 0; i < LANES; i++) pattern[i*16 +: 16] <= pattern[i*16 +: 16] + PAT_STEP;
      end
    end
  end

  assign s_awready  = active && (wr_state == W_ADDR);
  assign s_wready   = (wr_state == W_DATA) && bp_ok;
  assign s_bvalid   = (wr_state == W_RESP);
  assign s_bid      = w_id;
  assign s_bresp    = w_err ? 2'b10 : 2'b00;
  assign w_hs       = s_wvalid && s_wready;
  assign w_last_exp = (wcnt == w_len);

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_ADDR:  if (s_awvalid && s_awready) wr_next = W_DATA;
      W_DATA:  if (w_hs && (s_wlast || w_last_exp)) wr_next = W_RESP;
      W_RESP:  if (s_bready) wr_next = W_ADDR;
      default: wr_next = W_ADDR;
    endcase
  end

  // An early wlast ends the burst; a missing wlast is forced closed on beat awlen+1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_state   <= W_ADDR;
      w_id       <= '0;
      w_len      <= '0;
      wcnt       <= '0;
      w_err      <= 1'b0;
      o_wr_beats <= '0;
      o_wr_err   <= 1'b0;
    end else begin
      wr_state <= wr_next;
      if (s_awvalid && s_awready) begin
        w_id  <= s_awid;
        w_len <= s_awlen;
        wcnt  <= '0;
        w_err <= 1'b0;
      end
      if (w_hs) begin
        o_wr_beats <= o_wr_beats + 32'd1;
        wcnt       <= wcnt + 8'd1;
        if (s_wlast != w_last_exp) begin
          w_err    <= 1'b1;
          o_wr_err <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_tlk2711_axi_slave_bfm.sv
// Self-checking bench for tlk2711_axi_slave_bfm: read pattern scoreboard, write response
// scoreboard, counters and stall behaviour (AXI_BFM_BACKPRESSURE_EN aware).
module tb_tlk2711_axi_slave_bfm;
  localparam int          DW    = 128;
  localparam int          AW    = 40;
  localparam int          IW    = 4;
  localparam int          LANES = DW / 16;
  localparam logic [15:0] STEP  = 16'h8;
  localparam int          RW    = IW + 1 + 2 + DW;

  logic clk, rst;
  logic s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [IW-1:0] s_arid, s_rid, s_awid, s_bid;
  logic [AW-1:0] s_araddr, s_awaddr;
  logic [7:0] s_arlen, s_awlen;
  logic [DW-1:0] s_rdata, s_wdata;
  logic [1:0] s_rresp, s_bresp;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
  logic [DW/8-1:0] s_wstrb;
  logic [31:0] o_rd_beats, o_wr_beats;
  logic o_wr_err;

  tlk2711_axi_slave_bfm #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .AR_DEPTH(4), .RD_LATENCY(4), .PAT_STEP(STEP)
  ) dut (
    .clk(clk), .rst(rst),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .o_rd_beats(o_rd_beats), .o_wr_beats(o_wr_beats), .o_wr_err(o_wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  logic [RW-1:0]   exp_q[$];
  logic [IW+1:0]   exp_b_q[$];
  int unsigned     rd_k = 0;
  logic [31:0]     exp_rd_beats = 0;
  logic [31:0]     exp_wr_beats = 0;
  logic            exp_wr_err = 1'b0;
  int              gaps = 0;
  int              wstalls = 0;

  // Expected read data for beat k since reset: lane i = i + k*STEP (mod 2^16).
  function automatic logic [DW-1:0] pat(input int unsigned k);
    logic [DW-1:0] d;
    logic [31:0] v;
    for (int i = 0; i < LANES; i++) begin
      v = i + k * 32'(STEP);
      d[i*16 +: 16] = v[15:0];
    end
    return d;
  endfunction

  task automatic ar_send(input logic [IW-1:0] id, input logic [7:0] len, input bit keep);
    int w;
    @(negedge clk);
    s_arvalid = 1'b1; s_arid = id; s_arlen = len; s_araddr = AW'({$urandom, $urandom});
    w = 0;
    while (s_arready !== 1'b1 && w < 500) begin @(negedge clk); w++; end
    if (s_arready !== 1'b1) begin
      checks++;
      $display("FAIL ar_timeout arready=%b required=1", s_arready);
      s_arvalid = 1'b0;
      return;
    end
    @(posedge clk);
    for (int b = 0; b <= int'(len); b++) begin
      exp_q.push_back({id, (b == int'(len)), 2'b00, pat(rd_k)});
      rd_k++;
    end
    if (!keep) begin @(negedge clk); s_arvalid = 1'b0; end
  endtask

  // Runs from a negedge; mode 0 ready always, 1 drops rready 3 cycles at beat 2, 2 random.
  task automatic collect_reads(input int n, input int mode);
    int got, cyc, stall_left;
    bit rr, seen, held_v;
    logic [DW-1:0] hd;
    logic hl;
    logic [RW-1:0] e;
    got = 0; cyc = 0; stall_left = 3; seen = 0; held_v = 0; gaps = 0; hd = '0; hl = 1'b0;
    while (got < n && cyc < 2000) begin
      if (held_v && s_rvalid === 1'b1) begin
        checks++;
        if ({s_rlast, s_rdata} !== {hl, hd})
          $display("FAIL r_stable got=%h required=%h", {s_rlast, s_rdata}, {hl, hd});
        else passed++;
      end
      case (mode)
        0: rr = 1'b1;
        1: begin
          rr = !(got == 2 && stall_left > 0);
          if (!rr) stall_left--;
        end
        default: rr = 1'($urandom_range(0, 1));
      endcase
      s_rready = rr;
      if (s_rvalid === 1'b1) seen = 1'b1;
      else if (seen) gaps++;
      if (s_rvalid === 1'b1 && !rr) begin held_v = 1'b1; hd = s_rdata; hl = s_rlast; end
      else held_v = 1'b0;
      if (s_rvalid === 1'b1 && rr) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL r_unexpected got=%h required=none", s_rdata);
        else begin
          e = exp_q.pop_front();
          if ({s_rid, s_rlast, s_rresp, s_rdata} !== e)
            $display("FAIL r_beat got=%h required=%h", {s_rid, s_rlast, s_rresp, s_rdata}, e);
          else passed++;
        end
        got++;
        exp_rd_beats++;
      end
      @(negedge clk);
      cyc++;
    end
    if (got < n) begin checks++; $display("FAIL r_timeout beats=%0d required=%0d", got, n); end
    s_rready = 1'b0;
  endtask

  task automatic check_rd_count(input string name);
    checks++;
    if (o_rd_beats !== exp_rd_beats) $display("FAIL %s o_rd_beats=%0d required=%0d", name, o_rd_beats, exp_rd_beats);
    else passed++;
  endtask

  // wlast_at = beat carrying wlast (0 = never); DUT closes the burst at wlast or beat len+1.
  task automatic w_send(input logic [IW-1:0] id, input logic [7:0] len, input int wlast_at);
    int term, w;
    bit err;
    logic [IW+1:0] e;
    term = (wlast_at >= 1 && wlast_at <= int'(len) + 1) ? wlast_at : int'(len) + 1;
    err  = (wlast_at != int'(len) + 1);
    @(negedge clk);
    s_awvalid = 1'b1; s_awid = id; s_awlen = len; s_awaddr = AW'({$urandom, $urandom});
    w = 0;
    while (s_awready !== 1'b1 && w < 500) begin @(negedge clk); w++; end
    if (s_awready !== 1'b1) begin checks++; $display("FAIL aw_timeout awready=%b required=1", s_awready); return; end
    @(posedge clk);
    exp_b_q.push_back({id, err ? 2'b10 : 2'b00});
    @(negedge clk);
    s_awvalid = 1'b0;
    for (int j = 1; j <= term; j++) begin
      s_wvalid = 1'b1; s_wdata = DW'({$urandom, $urandom, $urandom, $urandom}); s_wstrb = '1;
      s_wlast = (j == wlast_at);
      w = 0;
      while (s_wready !== 1'b1 && w < 500) begin @(negedge clk); w++; wstalls++; end
      if (s_wready !== 1'b1) begin checks++; $display("FAIL w_timeout beat=%0d required=ready", j); return; end
      @(posedge clk);
      exp_wr_beats++;
      @(negedge clk);
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
    if (err) exp_wr_err = 1'b1;
    s_bready = 1'b1;
    w = 0;
    while (s_bvalid !== 1'b1 && w < 500) begin @(negedge clk); w++; end
    checks++;
    if (s_bvalid !== 1'b1) $display("FAIL b_timeout bvalid=%b required=1", s_bvalid);
    else begin
      e = exp_b_q.pop_front();
      if ({s_bid, s_bresp} !== e) $display("FAIL b_resp got=%h required=%h", {s_bid, s_bresp}, e);
      else passed++;
      @(posedge clk);
    end
    @(negedge clk);
    s_bready = 1'b0;
    checks++;
    if ({o_wr_beats, o_wr_err} !== {exp_wr_beats, exp_wr_err})
      $display("FAIL w_counters got=%0d/%b required=%0d/%b", o_wr_beats, o_wr_err, exp_wr_beats, exp_wr_err);
    else passed++;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({s_arready, s_awready, s_rvalid, s_wready, s_bvalid} !== 5'b0)
      $display("FAIL reset_handshakes got=%b required=00000", {s_arready, s_awready, s_rvalid, s_wready, s_bvalid});
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_arready, s_awready, s_rvalid, s_bvalid} !== 4'b1100)
      $display("FAIL release_ready got=%b required=1100", {s_arready, s_awready, s_rvalid, s_bvalid});
    else passed++;
    checks++;
    if ({o_rd_beats, o_wr_beats, o_wr_err} !== 65'b0)
      $display("FAIL reset_counters got=%0d/%0d/%b required=0/0/0", o_rd_beats, o_wr_beats, o_wr_err);
    else passed++;
  endtask

  task automatic test_single_read;
    int n;
    s_rready = 1'b1;
    ar_send(4'd3, 8'd3, 1'b0);
    n = 1;
    @(negedge clk);
    while (s_rvalid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++;
`ifdef AXI_BFM_BACKPRESSURE_EN
    if (n < 6) $display("FAIL first_r_latency got=%0d required>=6", n);
`else
    if (n != 6) $display("FAIL first_r_latency got=%0d required=6", n);
`endif
    else passed++;
    collect_reads(4, 0);
    check_rd_count("single_read");
  endtask

  task automatic test_outstanding;
    int total;
    total = 0;
    s_rready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      ar_send(IW'(i), 8'(i % 3), (i != 5));
      total += (i % 3) + 1;
    end
    checks++;
    if (s_arready !== 1'b0) $display("FAIL queue_full arready=%b required=0", s_arready);
    else passed++;
    collect_reads(total, 0);
    check_rd_count("outstanding");
  endtask

  task automatic test_r_stall;
    ar_send(4'd5, 8'd7, 1'b0);
    collect_reads(8, 1);
    check_rd_count("r_stall");
  endtask

  task automatic test_back_to_back;
    int total;
    logic [7:0] len;
    total = 0;
    for (int i = 0; i < 4; i++) begin
      len = 8'($urandom_range(0, 5));
      ar_send(IW'($urandom_range(0, 15)), len, (i != 3));
      total += int'(len) + 1;
    end
    collect_reads(total, 2);
    check_rd_count("back_to_back");
  endtask

  task automatic test_backpressure;
    ar_send(4'd7, 8'd15, 1'b0);
    @(negedge clk);
    while (s_rvalid !== 1'b1 && gaps < 100) begin @(negedge clk); gaps++; end
    collect_reads(16, 0);
    check_rd_count("bp_read");
    checks++;
`ifdef AXI_BFM_BACKPRESSURE_EN
    if (gaps == 0) $display("FAIL r_stalls got=%0d required>0", gaps);
`else
    if (gaps != 0) $display("FAIL r_stalls got=%0d required=0", gaps);
`endif
    else passed++;
    wstalls = 0;
    w_send(4'd2, 8'd15, 16);
    checks++;
`ifdef AXI_BFM_BACKPRESSURE_EN
    if (wstalls == 0) $display("FAIL w_stalls got=%0d required>0", wstalls);
`else
    if (wstalls != 0) $display("FAIL w_stalls got=%0d required=0", wstalls);
`endif
    else passed++;
  endtask

  initial begin
    rst = 1'b0; s_arvalid = 1'b0; s_arid = '0; s_araddr = '0; s_arlen = '0; s_rready = 1'b0;
    s_awvalid = 1'b0; s_awid = '0; s_awaddr = '0; s_awlen = '0;
    s_wvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_bready = 1'b0;
    test_reset();
    test_single_read();
    test_outstanding();
    test_r_stall();
    test_back_to_back();
    w_send(4'd9, 8'd7, 8);
    w_send(4'd4, 8'd7, 5);
    w_send(4'd6, 8'd3, 0);
    test_backpressure();
    checks++;
    if (exp_q.size() != 0) $display("FAIL leftover_reads got=%0d required=0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
